br_pe_adapter: RTL

PE-side local-port adapter for BrLiteNoC. It queues broadcast and targeted service requests from a processing element and injects them into the NoC local input with a req/ack handshake, stamping source address and a per-PE sequence id. In the other direction it accepts delivered flits from the NoC local output into a receive FIFO that the PE drains with valid/ready. One instance sits between each PE and its `BrLiteNoC` local port pair. It replaces the ad-hoc inject/ack logic currently written per bench.

---
 rtl/BrLitePkg.sv | 40 ++++
 rtl/br_fifo.sv | 54 +++++
 rtl/br_pe_adapter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/BrLitePkg.sv
// Shared BrLiteNoC types: flit layout, service codes, adapter TX entry and FSM states.
package BrLitePkg;

    localparam int unsigned BR_ADDR_W    = 8;
    localparam int unsigned BR_PAYLOAD_W = 32;
    localparam int unsigned BR_ID_W      = 5;

    typedef enum logic [1:0] {
        BR_SVC_ALL = 2'd0,
        BR_SVC_TGT = 2'd1,
        BR_SVC_MON = 2'd2,
        BR_SVC_CLR = 2'd3
    } br_svc_t;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]    seq_source;
        logic [BR_ADDR_W-1:0]    seq_target;
        logic [BR_PAYLOAD_W-1:0] payload;
        logic [BR_ID_W-1:0]      id;
        br_svc_t                 service;
    } br_data_t;

    // What the PE supplies per request; source and id are stamped at injection.
    typedef struct packed {
        logic [BR_ADDR_W-1:0]    seq_target;
        logic [BR_PAYLOAD_W-1:0] payload;
        br_svc_t                 service;
    } br_tx_entry_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_REQ  = 1'b1
    } br_tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_WAIT = 1'b1
    } br_rx_state_e;

endpackage

// File: rtl/br_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; a pop frees a slot for a same-cycle push.
module br_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  T                       wr_data,
    input  logic                   rd_en,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/br_pe_adapter.sv
// PE-side local-port adapter for BrLiteNoC: queued req/ack injection with stamped
// source/id, and req/ack capture of delivered flits into a PE-drained receive FIFO.
module br_pe_adapter
    import BrLitePkg::*;
#(
    parameter int unsigned SRC_ADDR = 0,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    input  logic [BR_ADDR_W-1:0]      tx_target_i,
    input  logic [BR_PAYLOAD_W-1:0]   tx_payload_i,
    input  br_svc_t                   tx_service_i,
    output br_data_t                  noc_flit_o,
    output logic                      noc_req_o,
    input  logic                      noc_ack_i,
    input  logic                      noc_busy_i,
    input  br_data_t                  noc_flit_i,
    input  logic                      noc_req_i,
    output logic                      noc_ack_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output br_data_t                  rx_flit_o,
    output logic [$clog2(TX_DEPTH):0] tx_count_o
);

    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    br_tx_entry_t     tx_in;
    br_tx_entry_t     tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_wr;
    logic             tx_pop;

    logic             rx_full;
    logic             rx_empty;
    logic             rx_wr;
    logic             rx_pop;
    logic [RX_CW-1:0] rx_count_unused;

    br_tx_state_e        tx_state_q, tx_state_d;
    br_data_t            flit_q, flit_d;
    logic                req_q, req_d;
    logic [BR_ID_W-1:0]  id_q, id_d;

    br_rx_state_e        rx_state_q, rx_state_d;
    logic                ack_q, ack_d;

    assign tx_in = '{seq_target: tx_target_i, payload: tx_payload_i, service: tx_service_i};

    // Ready reflects pre-pop state, so a full FIFO never takes a write even while popping.
    assign tx_ready_o = !tx_full;
    assign tx_wr      = tx_valid_i && !tx_full;

    br_fifo #(
        .T     (br_tx_entry_t),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .wr_en   (tx_wr),
        .wr_data (tx_in),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count_o)
    );

    // TX injection: busy only gates entering TX_REQ; flit is frozen while requesting.
    always_comb begin
        tx_state_d = tx_state_q;
        flit_d     = flit_q;
        req_d      = req_q;
        id_d       = id_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !noc_busy_i) begin
                    tx_state_d        = TX_REQ;
                    req_d             = 1'b1;
                    flit_d.seq_source = BR_ADDR_W'(SRC_ADDR);
                    flit_d.seq_target = tx_head.seq_target;
                    flit_d.payload    = tx_head.payload;
                    flit_d.service    = tx_head.service;
                    flit_d.id         = id_q;
                end
            end
            TX_REQ: begin
                if (noc_ack_i) begin
                    tx_state_d = TX_IDLE;
                    req_d      = 1'b0;
                    tx_pop     = 1'b1;
                    id_d       = id_q + BR_ID_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                req_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            flit_q     <= '0;
            req_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            flit_q     <= flit_d;
            req_q      <= req_d;
            id_q       <= id_d;
        end
    end

    assign noc_flit_o = flit_q;
    assign noc_req_o  = req_q;

    assign rx_pop     = !rx_empty && rx_ready_i;
    assign rx_valid_o = !rx_empty;

    // RX capture: one-cycle ack, then wait for req to drop so a held req is taken once.
    always_comb begin
        rx_state_d = rx_state_q;
        ack_d      = 1'b0;
        rx_wr      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (noc_req_i && (!rx_full || rx_pop)) begin
                    rx_state_d = RX_WAIT;
                    ack_d      = 1'b1;
                    rx_wr      = 1'b1;
                end
            end
            RX_WAIT: begin
                if (!noc_req_i) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q <= RX_IDLE;
            ack_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            ack_q      <= ack_d;
        end
    end

    assign noc_ack_o = ack_q;

    br_fifo #(
        .T     (br_data_t),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .wr_en   (rx_wr),
        .wr_data (noc_flit_i),
        .rd_en   (rx_pop),
        .rd_data (rx_flit_o),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count_unused)
    );

endmodule
